// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port (instruction/data) memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } arb_state_e;

    typedef enum logic {
        ReqInst,
        ReqData
    } req_id_e;

    localparam int unsigned DefaultTimeout = 255;

    // Request captured when arbitration is decided; drives the memory bus.
    typedef struct packed {
        req_id_e     id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Under contention prefer_inst picks the instruction port; otherwise the lone requester wins.
    function automatic req_id_e arb_winner(input logic inst_v, input logic data_v,
                                           input logic prefer_inst);
        if (inst_v && data_v) begin
            return prefer_inst ? ReqInst : ReqData;
        end
        return data_v ? ReqData : ReqInst;
    endfunction

endpackage

// File: rtl/timeout_cnt.sv
// Response-wait counter: cleared on entry to the response phase, counts cycles without a response.
module timeout_cnt #(
    parameter int unsigned Limit = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LastCnt = 16'(Limit - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // High in the cycle whose increment makes the count reach Limit.
    assign expired = enable && (cnt_q == LastCnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data requests onto one memory bus (IDLE/REQ/RESP FSM).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_re,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    output logic        inst_ready,
    input  logic        data_access,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        data_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    arb_state_e  state_q, state_d;
    mem_req_t    lat_q, lat_d;
    logic        mem_req_q, mem_req_d;
    logic        inst_ready_q, inst_ready_d;
    logic        data_ready_q, data_ready_d;
    logic        err_q, err_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic        inst_v, data_v;
    logic        prefer_inst;
    req_id_e     winner;
    logic        cnt_clear, cnt_enable, cnt_expired;
    logic [31:0] resp_data;

`ifdef MEM_ARB_RR_EN
    req_id_e last_q, last_d;
    assign prefer_inst = (last_q == ReqData);
`else
    assign prefer_inst = 1'b0;
`endif

    // A requester whose ready is pulsing this cycle is still holding its request; ignore it.
    assign inst_v = inst_re && !inst_ready_q;
    assign data_v = data_access && !data_ready_q;
    assign winner = arb_winner(inst_v, data_v, prefer_inst);

    assign cnt_clear  = (state_q == StReq) && mem_gnt;
    assign cnt_enable = (state_q == StResp) && !mem_rvalid;

    timeout_cnt #(
        .Limit(TIMEOUT)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expired(cnt_expired)
    );

    // Writes and timed-out accesses return zero data.
    assign resp_data = (mem_rvalid && !lat_q.we) ? mem_rdata : 32'd0;

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        mem_req_d    = mem_req_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        err_d        = 1'b0;
        inst_d       = inst_q;
        rd_data_d    = rd_data_q;
`ifdef MEM_ARB_RR_EN
        last_d       = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (inst_v || data_v) begin
                    state_d   = StReq;
                    mem_req_d = 1'b1;
                    lat_d.id  = winner;
                    if (winner == ReqData) begin
                        lat_d.we    = data_we;
                        lat_d.addr  = data_addr;
                        lat_d.wdata = wr_data;
                    end else begin
                        lat_d.we    = 1'b0;
                        lat_d.addr  = inst_addr;
                        lat_d.wdata = 32'd0;
                    end
`ifdef MEM_ARB_RR_EN
                    // Only contention advances the rotation, so the first clash after reset goes to data.
                    if (inst_v && data_v) begin
                        last_d = winner;
                    end
`endif
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    state_d   = StResp;
                    mem_req_d = 1'b0;
                end
            end
            StResp: begin
                if (mem_rvalid || cnt_expired) begin
                    state_d = StIdle;
                    err_d   = !mem_rvalid;
                    if (lat_q.id == ReqData) begin
                        data_ready_d = 1'b1;
                        rd_data_d    = resp_data;
                    end else begin
                        inst_ready_d = 1'b1;
                        inst_d       = resp_data;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            lat_q        <= '0;
            mem_req_q    <= 1'b0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            err_q        <= 1'b0;
            inst_q       <= 32'd0;
            rd_data_q    <= 32'd0;
`ifdef MEM_ARB_RR_EN
            last_q       <= ReqInst;
`endif
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            mem_req_q    <= mem_req_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
            err_q        <= err_d;
            inst_q       <= inst_d;
            rd_data_q    <= rd_data_d;
`ifdef MEM_ARB_RR_EN
            last_q       <= last_d;
`endif
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = lat_q.we;
    assign mem_addr   = lat_q.addr;
    assign mem_wdata  = lat_q.wdata;
    assign inst       = inst_q;
    assign inst_ready = inst_ready_q;
    assign rd_data    = rd_data_q;
    assign data_ready = data_ready_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transaction rounds.
module tb_mem_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_re;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        inst_ready;
    logic        data_access;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        data_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_inst = 32'd0;
    logic [31:0] exp_rd = 32'd0;
    bit          rr_last_data = 1'b0;

    mem_arbiter #(
        .TIMEOUT(T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_re    (inst_re),
        .inst_addr  (inst_addr),
        .inst       (inst),
        .inst_ready (inst_ready),
        .data_access(data_access),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .data_ready (data_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req"}, 32'(mem_req), 32'd0);
        check({tag, "_irdy"}, 32'(inst_ready), 32'd0);
        check({tag, "_drdy"}, 32'(data_ready), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // One access from the cycle after its arbitration decision up to and including its ready cycle.
    // rv_at: RESP cycle carrying mem_rvalid; beyond T means timeout (T+1 adds a stray rvalid).
    task automatic serve(input bit is_data, input logic [31:0] addr, input bit we,
                         input logic [31:0] wdata, input int gnt_wait, input int rv_at,
                         input logic [31:0] rdata, input bit drop_inst, input bit drop_data);
        int          k;
        bit          timed_out;
        logic [31:0] resp;
        for (int i = 0; i <= gnt_wait; i++) begin
            step();
            if (i == 0 && drop_inst) inst_re = 1'b0;
            if (i == 0 && drop_data) data_access = 1'b0;
            mem_gnt    = (i == gnt_wait);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            check("req_high", 32'(mem_req), 32'd1);
            check("bus_addr", mem_addr, addr);
            check("bus_we", 32'(mem_we), 32'(we));
            check("bus_wdata", mem_wdata, wdata);
            check("irdy_req", 32'(inst_ready), 32'd0);
            check("drdy_req", 32'(data_ready), 32'd0);
        end
        k = 0;
        while (k != rv_at && k != T) begin
            k++;
            step();
            mem_gnt    = 1'($urandom_range(0, 1));
            mem_rvalid = (k == rv_at);
            mem_rdata  = (k == rv_at) ? rdata : $urandom;
            check_quiet("resp");
        end
        step();
        timed_out  = (rv_at > T);
        mem_gnt    = 1'($urandom_range(0, 1));
        mem_rvalid = (rv_at == T + 1);
        mem_rdata  = $urandom;
        resp = (timed_out || we) ? 32'd0 : rdata;
        if (is_data) exp_rd = resp;
        else exp_inst = resp;
        check("inst_ready", 32'(inst_ready), 32'(!is_data));
        check("data_ready", 32'(data_ready), 32'(is_data));
        check("err", 32'(err), 32'(timed_out));
        check("inst", inst, exp_inst);
        check("rd_data", rd_data, exp_rd);
        check("req_in_ready", 32'(mem_req), 32'd0);
    endtask

    // Both requests (as enabled) raised together; expected service order comes from the arbitration rule.
    task automatic round(input bit inst_on, input bit data_on, input logic [31:0] iaddr,
                         input logic [31:0] daddr, input bit dwe, input logic [31:0] dwdata,
                         input int ig, input int ikr, input logic [31:0] irdata,
                         input int dg, input int dkr, input logic [31:0] drdata);
        bit data_first;
        inst_re     = inst_on;
        inst_addr   = iaddr;
        data_access = data_on;
        data_we     = dwe;
        data_addr   = daddr;
        wr_data     = dwdata;
        mem_gnt     = 1'($urandom_range(0, 1));
        mem_rvalid  = 1'($urandom_range(0, 1));
        if (inst_on && data_on) begin
`ifdef MEM_ARB_RR_EN
            data_first   = !rr_last_data;
            rr_last_data = data_first;
`else
            data_first = 1'b1;
`endif
        end else begin
            data_first = data_on;
        end
        if (data_first) begin
            serve(1'b1, daddr, dwe, dwdata, dg, dkr, drdata, 1'b0, 1'b0);
            if (inst_on) serve(1'b0, iaddr, 1'b0, 32'd0, ig, ikr, irdata, 1'b0, 1'b1);
        end else begin
            serve(1'b0, iaddr, 1'b0, 32'd0, ig, ikr, irdata, 1'b0, 1'b0);
            if (data_on) serve(1'b1, daddr, dwe, dwdata, dg, dkr, drdata, 1'b1, 1'b0);
        end
        step();
        inst_re     = 1'b0;
        data_access = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        check_quiet("no_dup");
        step();
        check_quiet("idle");
        check("inst_hold", inst, exp_inst);
        check("rd_hold", rd_data, exp_rd);
    endtask

    task automatic reset_mid();
        inst_re   = 1'b1;
        inst_addr = 32'h0000_0400;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        step();
        rst        = 1'b0;
        inst_re    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        exp_inst     = 32'd0;
        exp_rd       = 32'd0;
        rr_last_data = 1'b0;
        check_quiet("rst_now");
        check("rst_inst", inst, 32'd0);
        check("rst_rd", rd_data, 32'd0);
        step();
        mem_rvalid = 1'b0;
        check_quiet("rst_late");
        check("rst_inst_late", inst, 32'd0);
        step();
        check_quiet("rst_after");
    endtask

    initial begin
        rst         = 1'b1;
        inst_re     = 1'b0;
        inst_addr   = 32'd0;
        data_access = 1'b0;
        data_we     = 1'b0;
        data_addr   = 32'd0;
        wr_data     = 32'd0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'd0;
        step();
        step();
        rst = 1'b0;
        check_quiet("reset");
        check("reset_inst", inst, 32'd0);
        check("reset_rd", rd_data, 32'd0);
        check("reset_addr", mem_addr, 32'd0);

        // Single fetch, minimum latency.
        round(1, 0, 32'h100, 32'h0, 0, 32'h0, 0, 1, 32'h0000_0013, 0, 1, 32'h0);
        // Contention: load vs fetch.
        round(1, 1, 32'h104, 32'h200, 0, 32'h1234_5678, 0, 1, 32'h0000_0093, 1, 2,
              32'hA5A5_0001);
        // Repeated contention: order depends on arbitration mode.
        for (int r = 0; r < 4; r++) begin
            round(1, 1, 32'h108 + 32'(r * 4), 32'h210 + 32'(r * 4), 0, 32'h0, 0, 1,
                  32'h1000 + 32'(r), 0, 1, 32'h2000 + 32'(r));
        end
        // Store with gnt held low for 4 cycles.
        round(0, 1, 32'h0, 32'h300, 1, 32'hDEAD_BEEF, 0, 1, 32'h0, 4, 1, 32'h5555_AAAA);
        // Timeouts and the boundary where rvalid arrives on the expiring cycle.
        round(0, 1, 32'h0, 32'h310, 0, 32'h0, 0, 1, 32'h0, 0, T + 1, 32'h7777_7777);
        round(1, 0, 32'h120, 32'h0, 0, 32'h0, 1, T + 2, 32'h8888_8888, 0, 1, 32'h0);
        round(0, 1, 32'h0, 32'h320, 0, 32'h0, 0, 1, 32'h0, 0, T, 32'h9999_0004);
        round(1, 0, 32'h124, 32'h0, 0, 32'h0, 0, T, 32'h0BAD_0004, 0, 1, 32'h0);
        // Reset during RESP, then a normal fetch from IDLE.
        reset_mid();
        round(1, 0, 32'h100, 32'h0, 0, 32'h0, 0, 1, 32'h0000_0013, 0, 1, 32'h0);
        round(1, 1, 32'h130, 32'h330, 0, 32'h0, 0, 1, 32'h0000_1111, 0, 1, 32'h0000_2222);

        for (int n = 0; n < 60; n++) begin
            bit io, dn;
            io = 1'($urandom_range(0, 1));
            dn = 1'($urandom_range(0, 1));
            if (!io && !dn) io = 1'b1;
            round(io, dn, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(1, T + 2)), $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(1, T + 2)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
